// File: rtl/microcode_queue_pkg.sv
// Shared types for the decode-to-execute micro-op queue.
// An entry is a decoded uop tagged with the PC it came from.
package microcode_queue_pkg;

  typedef logic [31:0] int_reg_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu_op;
  } micro_code_t;

  typedef struct packed {
    micro_code_t uop;
    int_reg_t    pc;
  } entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/microcode_queue_storage.sv
// Entry array for the micro-op queue: ENQ_W write ports, DEQ_W combinational
// read ports, all addressed by queue pointers.
module microcode_queue_storage
  import microcode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 1,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic                         clk,
  input  logic [ENQ_W-1:0]             wr_en,
  input  logic [ENQ_W-1:0][PTR_W-1:0]  wr_addr,
  input  entry_t [ENQ_W-1:0]           wr_data,
  input  logic [DEQ_W-1:0][PTR_W-1:0]  rd_addr,
  output entry_t [DEQ_W-1:0]           rd_data
);

  entry_t mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and count,
  // so clearing storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_W; k++) begin
      if (wr_en[k]) mem_q[wr_addr[k]] <= wr_data[k];
    end
  end

  always_comb begin
    for (int i = 0; i < DEQ_W; i++) begin
      rd_data[i] = mem_q[rd_addr[i]];
    end
  end

endmodule

// File: rtl/microcode_queue.sv
// In-order multi-lane FIFO of decoded uops between decode and execute.
// Holds the pointers, occupancy and handshakes; storage lives in the sub-module.
module microcode_queue
  import microcode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [ENQ_W-1:0]             enq_valid,
  output logic                         enq_ready,
  input  micro_code_t [ENQ_W-1:0]      enq_uop,
  input  int_reg_t [ENQ_W-1:0]         enq_pc,
  output logic [DEQ_W-1:0]             deq_valid,
  input  logic [DEQ_W-1:0]             deq_ready,
  output micro_code_t [DEQ_W-1:0]      deq_uop,
  output int_reg_t [DEQ_W-1:0]         deq_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, n_enq, n_deq;
  logic             take;

  logic [ENQ_W-1:0]            wr_en;
  logic [ENQ_W-1:0][PTR_W-1:0] wr_addr;
  entry_t [ENQ_W-1:0]          wr_data;
  logic [DEQ_W-1:0][PTR_W-1:0] rd_addr;
  entry_t [DEQ_W-1:0]          rd_data;

  // Registered count only: a full queue refuses even while it is draining.
  assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_W);
  assign count     = count_q;

  // NOTE: every output of a combinational block gets a value on every path
  // (here by a default first), otherwise synthesis infers a latch.
  always_comb begin
    n_enq = '0;
    for (int k = 0; k < ENQ_W; k++) begin
      wr_en[k]       = enq_ready && enq_valid[k] && !flush;
      wr_addr[k]     = tail_q + PTR_W'(k);
      wr_data[k].uop = enq_uop[k];
      wr_data[k].pc  = enq_pc[k];
      if (enq_ready && enq_valid[k]) n_enq = n_enq + CNT_W'(1);
    end
  end

  // A lane pops only if every lane ahead of it pops too.
  always_comb begin
    n_deq = '0;
    take  = 1'b1;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i] = count_q > CNT_W'(i);
      rd_addr[i]   = head_q + PTR_W'(i);
      deq_uop[i]   = rd_data[i].uop;
      deq_pc[i]    = rd_data[i].pc;
      take         = take && deq_valid[i] && deq_ready[i];
      if (take) n_deq = n_deq + CNT_W'(1);
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + n_enq - n_deq;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  microcode_queue_storage #(
    .DEPTH (DEPTH),
    .ENQ_W (ENQ_W),
    .DEQ_W (DEQ_W),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  a_enq_prefix : assert property (@(posedge clk) disable iff (reset)
    ((enq_valid & (enq_valid + ENQ_W'(1))) == '0));
  a_count_max : assert property (@(posedge clk) disable iff (reset)
    (count_q <= CNT_W'(DEPTH)));
  a_empty_no_valid : assert property (@(posedge clk) disable iff (reset)
    ((count_q == '0) |-> (deq_valid == '0)));

endmodule

// File: tb/tb_microcode_queue.sv
// Randomised bench for microcode_queue (DEPTH=8, ENQ_W=2, DEQ_W=2) with a
// queue-based scoreboard; a negedge monitor checks every cycle's outputs.
module tb_microcode_queue;
  import microcode_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int UOP_W = $bits(micro_code_t);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic [ENQ_W-1:0]        enq_valid;
  logic                    enq_ready;
  micro_code_t [ENQ_W-1:0] enq_uop;
  int_reg_t [ENQ_W-1:0]    enq_pc;
  logic [DEQ_W-1:0]        deq_valid;
  logic [DEQ_W-1:0]        deq_ready;
  micro_code_t [DEQ_W-1:0] deq_uop;
  int_reg_t [DEQ_W-1:0]    deq_pc;
  logic [3:0]              count;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     mon_en   = 1'b0;

  always #5 clk = ~clk;

  microcode_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_uop   (enq_uop),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_uop   (deq_uop),
    .deq_pc    (deq_pc),
    .count     (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: the model's contents are the queue sb; its size is the occupancy.
  always @(negedge clk) begin
    int         n;
    int         pops;
    bit         tk;
    logic [1:0] exp_v;
    if (mon_en && !reset) begin
      n = sb.size();
      check("count", 64'(count), 64'(n));
      check("enq_ready", 64'(enq_ready), 64'((DEPTH - n) >= ENQ_W));
      for (int i = 0; i < DEQ_W; i++) exp_v[i] = (n > i);
      check("deq_valid", 64'(deq_valid), 64'(exp_v));
      pops = 0;
      tk   = 1'b1;
      for (int i = 0; i < DEQ_W; i++) begin
        tk = tk && (n > i) && deq_ready[i];
        if (tk) begin
          check("deq_entry", 64'({deq_uop[i], deq_pc[i]}), 64'(sb[i]));
          pops++;
        end
      end
      repeat (pops) void'(sb.pop_front());
    end
  end

  // Called at posedge+1; drives one cycle, then records accepted entries.
  task automatic step(input logic fl, input logic [1:0] ev, input logic [1:0] dr,
                      input int_reg_t pc0, input int_reg_t pc1);
    entry_t e[2];
    bit     acc;
    acc      = (DEPTH - sb.size()) >= ENQ_W;
    e[0].uop = micro_code_t'(UOP_W'($urandom));
    e[0].pc  = pc0;
    e[1].uop = micro_code_t'(UOP_W'($urandom));
    e[1].pc  = pc1;
    flush      = fl;
    enq_valid  = ev;
    enq_uop[0] = e[0].uop;
    enq_uop[1] = e[1].uop;
    enq_pc[0]  = e[0].pc;
    enq_pc[1]  = e[1].pc;
    deq_ready  = dr;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (acc) begin
      for (int k = 0; k < ENQ_W; k++) if (ev[k]) sb.push_back(e[k]);
    end
    flush     = 1'b0;
    enq_valid = '0;
    deq_ready = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int_reg_t   p_first;
    logic [1:0] ev;
    reset     = 1'b1;
    flush     = 1'b0;
    enq_valid = '0;
    deq_ready = '0;
    enq_uop   = '0;
    enq_pc    = '0;
    #12;
    check("reset_count", 64'(count), 64'd0);
    check("reset_deq_valid", 64'(deq_valid), 64'd0);
    check("reset_enq_ready", 64'(enq_ready), 64'd1);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single lane-0 enqueue appears one cycle later.
    step(1'b0, 2'b01, 2'b00, 32'h100, 32'h0);
    check("t1_deq_valid", 64'(deq_valid), 64'b01);
    check("t1_deq_pc", 64'(deq_pc[0]), 64'h100);
    check("t1_count", 64'(count), 64'd1);
    step(1'b1, 2'b00, 2'b00, 32'h0, 32'h0);

    // Fill by pairs with no consumer.
    p_first = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11, 2'b00, 32'h1000 + 32'(16 * i), 32'h1008 + 32'(16 * i));
      check("t2_count", 64'(count), 64'(2 * (i + 1)));
      check("t2_enq_ready", 64'(enq_ready), 64'(i < 3 ? 1 : 0));
    end
    step(1'b0, 2'b11, 2'b00, 32'hdead, 32'hbeef);
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_head_kept", 64'(deq_pc[0]), 64'(p_first));

    // Full: a concurrent dequeue does not make room for the enqueue.
    step(1'b0, 2'b11, 2'b01, 32'hdead, 32'hbeef);
    check("t3_count7", 64'(count), 64'd7);
    check("t3_ready_at7", 64'(enq_ready), 64'd0);
    step(1'b0, 2'b11, 2'b00, 32'hdead, 32'hbeef);
    check("t3_still7", 64'(count), 64'd7);

    // Lane 1 cannot pop without lane 0.
    step(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
    step(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
    check("t4_count3", 64'(count), 64'd3);
    step(1'b0, 2'b00, 2'b10, 32'h0, 32'h0);
    check("t4_no_pop", 64'(count), 64'd3);
    step(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
    check("t4_pop2", 64'(count), 64'd1);

    // Flush wins over simultaneous enqueue and dequeue.
    step(1'b0, 2'b11, 2'b00, 32'h2000, 32'h2004);
    step(1'b0, 2'b11, 2'b00, 32'h2008, 32'h200c);
    check("t5_count5", 64'(count), 64'd5);
    step(1'b1, 2'b11, 2'b01, 32'h3000, 32'h3004);
    check("t5_flush_count", 64'(count), 64'd0);
    check("t5_flush_valid", 64'(deq_valid), 64'd0);
    step(1'b0, 2'b01, 2'b00, 32'h200, 32'h0);
    check("t5_new_head", 64'(deq_pc[0]), 64'h200);
    check("t5_new_count", 64'(count), 64'd1);

    // Asynchronous reset in the middle of a cycle.
    step(1'b0, 2'b11, 2'b00, 32'h4000, 32'h4004);
    step(1'b0, 2'b01, 2'b00, 32'h4008, 32'h0);
    check("t6_count4", 64'(count), 64'd4);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("t6_async_count", 64'(count), 64'd0);
    check("t6_async_valid", 64'(deq_valid), 64'd0);
    check("t6_async_ready", 64'(enq_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 2'b01, 2'b00, 32'h300, 32'h0);
    check("t6_resume_pc", 64'(deq_pc[0]), 64'h300);
    check("t6_resume_count", 64'(count), 64'd1);

    // Long random stream across many pointer wraps.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 2))
        0:       ev = 2'b00;
        1:       ev = 2'b01;
        default: ev = 2'b11;
      endcase
      step($urandom_range(0, 63) == 0, ev, 2'($urandom), $urandom, $urandom);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
